// File: rtl/otp_macro_cmd_seq.sv
// OTP macro command sequencer.
// Issues the mandatory Init command after reset, then forwards one host request
// at a time to the macro over a ready/valid command channel and returns the
// macro response to the host. A per-state watchdog and a spurious-response
// detector move the block into a sticky fatal state that only reset can clear.

package otp_macro_cmd_seq_pkg;

    // Macro command encodings. Read is the all-zero encoding used at reset.
    typedef enum logic [2:0] {
        Read     = 3'b000,
        Write    = 3'b001,
        ReadRaw  = 3'b010,
        WriteRaw = 3'b011,
        Init     = 3'b111
    } cmd_e;

    // Macro error codes returned with each response.
    typedef enum logic [2:0] {
        NoError              = 3'h0,
        MacroError           = 3'h1,
        MacroEccCorrError    = 3'h2,
        MacroEccUncorrError  = 3'h3,
        MacroWriteBlankError = 3'h4
    } err_e;

    // Address width helper that never returns zero.
    function automatic int vbits(int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

module otp_macro_cmd_seq
    import otp_macro_cmd_seq_pkg::*;
#(
    parameter int Width         = 16,
    parameter int Depth         = 1024,
    parameter int SizeWidth     = 2,
    parameter int TimeoutCycles = 1024,
    localparam int AddrWidth    = vbits(Depth),
    localparam int IfWidth      = (2 ** SizeWidth) * Width
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // Host side
    input  logic                 host_req_i,
    output logic                 host_gnt_o,
    input  cmd_e                 host_cmd_i,
    input  logic [AddrWidth-1:0] host_addr_i,
    input  logic [SizeWidth-1:0] host_size_i,
    input  logic [IfWidth-1:0]   host_wdata_i,
    output logic                 host_rsp_valid_o,
    output logic [IfWidth-1:0]   host_rdata_o,
    output err_e                 host_err_o,
    output logic                 host_timeout_o,
    output logic                 init_done_o,
    output logic                 fatal_o,
    // Macro command channel
    output logic                 otp_valid_o,
    input  logic                 otp_ready_i,
    output cmd_e                 otp_cmd_o,
    output logic [AddrWidth-1:0] otp_addr_o,
    output logic [SizeWidth-1:0] otp_size_o,
    output logic [IfWidth-1:0]   otp_wdata_o,
    // Macro response channel
    input  logic                 otp_valid_i,
    input  logic [IfWidth-1:0]   otp_rdata_i,
    input  err_e                 otp_err_i
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles);

    // Multi-bit spaced encodings so that a single flipped bit never lands on
    // another legal state; every unused code is caught by the default branch.
    typedef enum logic [6:0] {
        ResetSt    = 7'b1001011,
        InitReqSt  = 7'b0110010,
        InitWaitSt = 7'b1100101,
        IdleSt     = 7'b0001110,
        CmdSt      = 7'b1010000,
        RspWaitSt  = 7'b0111101,
        ErrorSt    = 7'b1111111
    } state_e;

    state_e               state_q;
    logic [CntWidth-1:0]  cnt_q;
    cmd_e                 cmd_q;
    logic [AddrWidth-1:0] addr_q;
    logic [SizeWidth-1:0] size_q;
    logic [IfWidth-1:0]   wdata_q;

    logic wait_st;
    logic timeout_hit;
    logic host_accept;
    logic fwd_cmd;
    logic read_cmd;

    assign wait_st     = (state_q == InitReqSt) || (state_q == InitWaitSt) ||
                         (state_q == CmdSt)     || (state_q == RspWaitSt);
    assign timeout_hit = wait_st && (cnt_q >= CntLimit);
    assign host_accept = host_req_i && host_gnt_o;
    assign fwd_cmd     = (host_cmd_i == Read)  || (host_cmd_i == ReadRaw) ||
                         (host_cmd_i == Write) || (host_cmd_i == WriteRaw);
    assign read_cmd    = (cmd_q == Read) || (cmd_q == ReadRaw);

    // Decode grant and the macro command channel from the current state.
    always_comb begin
        host_gnt_o  = (state_q == IdleSt) && !host_rsp_valid_o;
        otp_valid_o = 1'b0;
        otp_cmd_o   = Read;
        otp_addr_o  = '0;
        otp_size_o  = '0;
        otp_wdata_o = '0;
        if (state_q == InitReqSt) begin
            otp_valid_o = 1'b1;
            otp_cmd_o   = Init;
        end else if (state_q == CmdSt) begin
            otp_valid_o = 1'b1;
            otp_cmd_o   = cmd_q;
            otp_addr_o  = addr_q;
            otp_size_o  = size_q;
            otp_wdata_o = wdata_q;
        end
    end

    // Main sequencer: state, watchdog, latched request and registered host outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ResetSt;
            cnt_q            <= '0;
            cmd_q            <= Read;
            addr_q           <= '0;
            size_q           <= '0;
            wdata_q          <= '0;
            host_rsp_valid_o <= 1'b0;
            host_rdata_o     <= '0;
            host_err_o       <= NoError;
            host_timeout_o   <= 1'b0;
            init_done_o      <= 1'b0;
            fatal_o          <= 1'b0;
        end else begin
            host_rsp_valid_o <= 1'b0;
            host_timeout_o   <= 1'b0;
            if (wait_st) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
            unique case (state_q)
                ResetSt: begin
                    cnt_q <= '0;
                    if (otp_valid_i) begin
                        state_q <= ErrorSt;
                        fatal_o <= 1'b1;
                    end else begin
                        state_q <= InitReqSt;
                    end
                end
                InitReqSt: begin
                    if (otp_valid_i || timeout_hit) begin
                        state_q <= ErrorSt;
                        fatal_o <= 1'b1;
                        cnt_q   <= '0;
                    end else if (otp_ready_i) begin
                        state_q <= InitWaitSt;
                        cnt_q   <= '0;
                    end
                end
                InitWaitSt: begin
                    if (timeout_hit) begin
                        state_q <= ErrorSt;
                        fatal_o <= 1'b1;
                        cnt_q   <= '0;
                    end else if (otp_valid_i) begin
                        state_q     <= IdleSt;
                        init_done_o <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                IdleSt: begin
                    cnt_q <= '0;
                    if (otp_valid_i) begin
                        state_q <= ErrorSt;
                        fatal_o <= 1'b1;
                    end else if (host_accept) begin
                        cmd_q   <= host_cmd_i;
                        addr_q  <= host_addr_i;
                        size_q  <= host_size_i;
                        wdata_q <= host_wdata_i;
                        if (fwd_cmd) begin
                            state_q <= CmdSt;
                        end else begin
                            host_rsp_valid_o <= 1'b1;
                            host_err_o       <= MacroError;
                        end
                    end
                end
                CmdSt: begin
                    if (otp_valid_i) begin
                        state_q <= ErrorSt;
                        fatal_o <= 1'b1;
                        cnt_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q          <= ErrorSt;
                        fatal_o          <= 1'b1;
                        cnt_q            <= '0;
                        host_rsp_valid_o <= 1'b1;
                        host_timeout_o   <= 1'b1;
                        host_err_o       <= MacroError;
                    end else if (otp_ready_i) begin
                        state_q <= RspWaitSt;
                        cnt_q   <= '0;
                    end
                end
                RspWaitSt: begin
                    if (timeout_hit) begin
                        state_q          <= ErrorSt;
                        fatal_o          <= 1'b1;
                        cnt_q            <= '0;
                        host_rsp_valid_o <= 1'b1;
                        host_timeout_o   <= 1'b1;
                        host_err_o       <= MacroError;
                    end else if (otp_valid_i) begin
                        state_q          <= IdleSt;
                        cnt_q            <= '0;
                        host_rsp_valid_o <= 1'b1;
                        host_err_o       <= otp_err_i;
                        if (read_cmd) begin
                            host_rdata_o <= otp_rdata_i;
                        end
                    end
                end
                ErrorSt: begin
                    fatal_o <= 1'b1;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ErrorSt;
                    fatal_o <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Once fatal, the block must stay fatal until reset.
    FatalSticky_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fatal_o |=> fatal_o);

    // The host is never granted while a macro command is being presented.
    GntExclusive_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(host_gnt_o && otp_valid_o));

    // The watchdog never runs past its limit.
    CntBound_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntLimit);

endmodule
